s2p_scan_ctrl: RTL and testbench
================================

S2P_SCAN_CTRL -- requirements
Module: s2p_scan_ctrl

Interface
REQ-001 SHALL have parameter NBIT, default 64: bits per serial chain, legal range 2..256.
REQ-002 SHALL have parameter NCH, default 2: number of parallel chains sharing sclk/sld_n, legal range 1..8.
REQ-003 SHALL have parameter DIV, default 4: clk cycles per sclk half-period, legal range 1..255.
REQ-004 SHALL have parameter FILT, default 2: consecutive identical frames required before commit, legal range 1..4.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port warm_rst, input, 1: asynchronous, active-high reset of the scan engine.
REQ-007 SHALL have port cold_rst, input, 1: asynchronous, active-high reset of the committed outputs only.
REQ-008 SHALL have port en, input, 1: scanning enable.
REQ-009 SHALL have port si, input, NCH: serial data, one bit per chain, asynchronous to clk.
REQ-010 SHALL have port sclk, output, 1: registered shift clock.
REQ-011 SHALL have port sld_n, output, 1: registered active-low parallel load strobe.
REQ-012 SHALL have port po, output, NCH*NBIT: committed data; chain c occupies bits [c*NBIT +: NBIT].
REQ-013 SHALL have port po_valid, output, 1: set at the first commit, cleared only by cold_rst.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at the end of every frame.
REQ-015 SHALL have port chg, output, NCH: one-cycle pulse per chain whose committed value changed.

Function
REQ-016 SHALL run FSM IDLE -> LOAD -> SHIFT -> CHECK -> IDLE (or -> LOAD if en=1); a half-period counter (0..DIV-1) paces LOAD and SHIFT.
REQ-017 SHALL leave IDLE for LOAD on the cycle after en=1 is sampled.
REQ-018 SHALL, in LOAD, drive sld_n=0 and sclk=0 for 2*DIV cycles, then enter SHIFT with sld_n=1.
REQ-019 SHALL, in SHIFT, toggle sclk every DIV cycles for exactly NBIT rising edges, and hold sclk=0 on exit.
REQ-020 SHALL synchronise si through 2 flops and capture bit k (k=0 first) of each chain into the shadow register on the clk cycle of sclk rising edge k.
REQ-021 SHALL, in CHECK (1 cycle), pulse frame_done and compare the shadow with the previous shadow: equal increments a match count saturating at FILT-1; unequal clears it to 0.
REQ-022 SHALL commit the shadow to po when the match count reaches FILT-1 (FILT=1: every frame) and set po_valid.
REQ-023 SHALL pulse chg[c] in the commit cycle iff chain c's new value differs from its old po value; chg SHALL stay 0 at the first commit after cold_rst.
REQ-024 SHALL, when en falls mid-frame, complete the frame including CHECK and then go to IDLE; no partial frame is committed.
REQ-025 SHALL hold sclk=0, sld_n=1 in IDLE.
REQ-026 SHALL give frame length 2*DIV*(NBIT+1)+1 clk cycles, and commit latency of FILT frames after a stable input change.

Reset
REQ-027 SHALL, on warm_rst, reset FSM to IDLE, counters and shadow/previous registers to 0, sclk=0, sld_n=1, frame_done=0, chg=0, and SHALL NOT alter po or po_valid.
REQ-028 SHALL, on cold_rst, clear po and po_valid to 0 and force the next commit to be treated as first (no chg).
REQ-029 SHALL restart with a full LOAD after warm_rst is released mid-frame.

Structure
REQ-030 SHALL place the FSM state encoding and the clogb2 width function in the shared package s2p_pkg.
REQ-031 SHALL instantiate sub-module s2p_frame_filter (compare, match count, commit, chg) once per chain.

Verification
REQ-032 SHALL check NBIT=8, NCH=2, DIV=2, FILT=1, chains 0xA5/0x3C: after 1 frame, po=0x3CA5, po_valid=1, chg=00, frame_done once per 37 cycles.
REQ-033 SHALL check FILT=2 with chain0 0x01, 0x02, 0x02: po stays 0x01 after frame 2; po=0x02 and chg=01 after frame 3.
REQ-034 SHALL check en dropped in SHIFT bit 3: exactly 8 sclk rising edges occur, then IDLE with sclk=0, sld_n=1.
REQ-035 SHALL check warm_rst mid-SHIFT with po=0x3CA5: po is unchanged, the next frame starts with sld_n low for 4 cycles.
REQ-036 SHALL check cold_rst after commit: po=0, po_valid=0, and the next commit raises no chg.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel scan controller: FSM encoding
// and the width helper used to size its counters.
package s2p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } scan_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/s2p_frame_filter.sv
// Per-chain frame filter: debounces consecutive identical frames, commits the
// stable value and flags a change against the previously committed value.
module s2p_frame_filter
    import s2p_pkg::*;
#(
    parameter int NBIT = 64,
    parameter int FILT = 2
) (
    input  logic            clk,
    input  logic            warm_rst,
    input  logic            cold_rst,
    input  logic            check_i,
    input  logic [NBIT-1:0] shadow_i,
    output logic [NBIT-1:0] po_o,
    output logic            chg_o,
    output logic            commit_o
);

    localparam int CW = clogb2(FILT);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    logic [NBIT-1:0] prev_q, prev_d;
    logic [NBIT-1:0] po_q, po_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            chg_q, chg_d;
    logic            commit_s;

    // Match counting on the CHECK strobe; commit once the count sits at FILT-1.
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        po_d     = po_q;
        first_d  = first_q;
        chg_d    = 1'b0;
        commit_s = 1'b0;
        if (check_i) begin
            prev_d = shadow_i;
            if (shadow_i == prev_q) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
            if (cnt_d == CNT_MAX) begin
                commit_s = 1'b1;
                po_d     = shadow_i;
                first_d  = 1'b0;
                // The first commit after cold reset has nothing meaningful to compare against.
                chg_d    = ~first_q & (shadow_i != po_q);
            end else begin
                commit_s = 1'b0;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Scan-engine side state, cleared by warm reset.
    always_ff @(posedge clk or posedge warm_rst) begin
        if (warm_rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    // Committed value, owned by the cold-reset domain.
    always_ff @(posedge clk or posedge cold_rst) begin
        if (cold_rst) begin
            po_q    <= '0;
            first_q <= 1'b1;
        end else begin
            po_q    <= po_d;
            first_q <= first_d;
        end
    end

    assign po_o     = po_q;
    assign chg_o    = chg_q;
    assign commit_o = commit_s;

endmodule

// File: rtl/s2p_scan_ctrl.sv
// Scan engine driving shared sclk/sld_n to NCH external shift chains, capturing
// each frame into a shadow register and handing it to per-chain filters.
module s2p_scan_ctrl
    import s2p_pkg::*;
#(
    parameter int NBIT = 64,
    parameter int NCH  = 2,
    parameter int DIV  = 4,
    parameter int FILT = 2
) (
    input  logic                clk,
    input  logic                warm_rst,
    input  logic                cold_rst,
    input  logic                en,
    input  logic [NCH-1:0]      si,
    output logic                sclk,
    output logic                sld_n,
    output logic [NCH*NBIT-1:0] po,
    output logic                po_valid,
    output logic                frame_done,
    output logic [NCH-1:0]      chg
);

    localparam int HW = clogb2(DIV);
    localparam int BW = clogb2(NBIT);
    localparam logic [HW-1:0] HALF_MAX = HW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(NBIT - 1);

    scan_state_e state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          ph_q, ph_d;
    logic          sclk_q, sclk_d;
    logic          sld_n_q, sld_n_d;
    logic          done_q, done_d;
    logic          capture_s;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0][NBIT-1:0] shadow_q;
    logic [NCH-1:0] commit_s;
    logic          po_valid_q;

    // Next-state logic; ph_q marks the second half-period of LOAD.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        bit_d     = bit_q;
        ph_d      = ph_q;
        sclk_d    = 1'b0;
        sld_n_d   = 1'b1;
        done_d    = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                    half_d  = '0;
                    ph_d    = 1'b0;
                    sld_n_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sld_n_d = 1'b0;
                if (half_q == HALF_MAX) begin
                    half_d = '0;
                    if (ph_q) begin
                        state_d = ST_SHIFT;
                        ph_d    = 1'b0;
                        bit_d   = '0;
                        sld_n_d = 1'b1;
                    end else begin
                        ph_d = 1'b1;
                    end
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            ST_SHIFT: begin
                sclk_d = sclk_q;
                if (half_q == HALF_MAX) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        capture_s = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_MAX) begin
                            state_d = ST_CHECK;
                            done_d  = 1'b1;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            ST_CHECK: begin
                if (en) begin
                    state_d = ST_LOAD;
                    half_d  = '0;
                    ph_d    = 1'b0;
                    sld_n_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, pacing counters and registered strobes.
    always_ff @(posedge clk or posedge warm_rst) begin
        if (warm_rst) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            ph_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sld_n_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            sclk_q  <= sclk_d;
            sld_n_q <= sld_n_d;
            done_q  <= done_d;
        end
    end

    // Two-flop synchroniser for the asynchronous serial inputs.
    always_ff @(posedge clk or posedge warm_rst) begin
        if (warm_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= si;
            sync2_q <= sync1_q;
        end
    end

    // Bit k lands in the shadow on the clk edge that raises sclk for the k-th time.
    always_ff @(posedge clk or posedge warm_rst) begin
        if (warm_rst) begin
            shadow_q <= '0;
        end else if (capture_s) begin
            for (int c = 0; c < NCH; c++) begin
                shadow_q[c][bit_q] <= sync2_q[c];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chain
        s2p_frame_filter #(
            .NBIT (NBIT),
            .FILT (FILT)
        ) u_filter (
            .clk      (clk),
            .warm_rst (warm_rst),
            .cold_rst (cold_rst),
            .check_i  (done_q),
            .shadow_i (shadow_q[c]),
            .po_o     (po[c*NBIT +: NBIT]),
            .chg_o    (chg[c]),
            .commit_o (commit_s[c])
        );
    end

    // Sticky valid flag, cleared only with the committed data.
    always_ff @(posedge clk or posedge cold_rst) begin
        if (cold_rst) begin
            po_valid_q <= 1'b0;
        end else if (|commit_s) begin
            po_valid_q <= 1'b1;
        end
    end

    assign sclk       = sclk_q;
    assign sld_n      = sld_n_q;
    assign frame_done = done_q;
    assign po_valid   = po_valid_q;

endmodule

// File: tb/tb_s2p_scan_ctrl.sv
// Bench for s2p_scan_ctrl: two instances (FILT=1 and FILT=2) share one set of
// external chains; a frame-position model predicts every output each cycle.
module tb_s2p_scan_ctrl;

    localparam int NBIT = 8;
    localparam int NCH  = 2;
    localparam int DIV  = 2;
    localparam int FLEN = 2 * DIV * (NBIT + 1) + 1;

    logic clk = 1'b0;
    logic warm_rst, cold_rst, en;
    logic [NCH-1:0] si;
    logic sclk_a, sld_n_a, pov_a, fd_a;
    logic sclk_b, sld_n_b, pov_b, fd_b;
    logic [NCH*NBIT-1:0] po_a, po_b;
    logic [NCH-1:0] chg_a, chg_b;

    logic [1:0][7:0] stim;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rises = 0;

    // Model state: frame position (-1 = idle) and per-instance filter view.
    int pos;
    logic [7:0] frm [2];
    logic [7:0] prv [2][2];
    logic [7:0] mpo [2][2];
    int cnt [2][2];
    bit first [2][2];
    logic mvalid [2];
    logic [1:0] mchg [2];
    int filt [2];

    always #5 clk = ~clk;

    s2p_scan_ctrl #(.NBIT(NBIT), .NCH(NCH), .DIV(DIV), .FILT(1)) u_f1 (
        .clk(clk), .warm_rst(warm_rst), .cold_rst(cold_rst), .en(en), .si(si),
        .sclk(sclk_a), .sld_n(sld_n_a), .po(po_a), .po_valid(pov_a),
        .frame_done(fd_a), .chg(chg_a)
    );

    s2p_scan_ctrl #(.NBIT(NBIT), .NCH(NCH), .DIV(DIV), .FILT(2)) u_f2 (
        .clk(clk), .warm_rst(warm_rst), .cold_rst(cold_rst), .en(en), .si(si),
        .sclk(sclk_b), .sld_n(sld_n_b), .po(po_b), .po_valid(pov_b),
        .frame_done(fd_b), .chg(chg_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (fd_a !== 1'b1 && k < 200);
        total++;
        if (fd_a !== 1'b1) begin
            bad++;
            $display("FAIL %s: frame_done not seen within 200 cycles", name);
        end
    endtask

    task automatic wait_rises(input int n, input string name);
        int k;
        k = 0;
        while (rises < n && k < 400) begin
            tick(1);
            k++;
        end
        total++;
        if (rises < n) begin
            bad++;
            $display("FAIL %s: saw %0d sclk rises, needed %0d", name, rises, n);
        end
    endtask

    // External chains: parallel load while sld_n is low, shift after each sclk rise.
    initial begin
        logic [1:0][7:0] sr;
        logic ps;
        sr = '0;
        ps = 1'b0;
        si = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sld_n_a === 1'b0) begin
                sr = stim;
                si = {sr[1][0], sr[0][0]};
            end else if (sclk_a === 1'b1 && ps === 1'b0) begin
                sr[0] = sr[0] >> 1;
                sr[1] = sr[1] >> 1;
                si = {sr[1][0], sr[0][0]};
            end
            ps = sclk_a;
        end
    end

    // Behavioural model, advanced on every rising clock edge.
    initial begin
        pos = -1;
        filt[0] = 1;
        filt[1] = 2;
        for (int i = 0; i < 2; i++) begin
            mvalid[i] = 1'b0;
            mchg[i]   = 2'b00;
            frm[i]    = 8'h00;
            for (int c = 0; c < 2; c++) begin
                prv[i][c] = 8'h00;
                mpo[i][c] = 8'h00;
                cnt[i][c] = 0;
                first[i][c] = 1'b1;
            end
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) mchg[i] = 2'b00;
            if (cold_rst) begin
                for (int i = 0; i < 2; i++) begin
                    mvalid[i] = 1'b0;
                    for (int c = 0; c < 2; c++) begin
                        mpo[i][c] = 8'h00;
                        first[i][c] = 1'b1;
                    end
                end
            end
            if (warm_rst) begin
                pos = -1;
                for (int i = 0; i < 2; i++)
                    for (int c = 0; c < 2; c++) begin
                        prv[i][c] = 8'h00;
                        cnt[i][c] = 0;
                    end
            end else begin
                if (pos == FLEN - 1) begin
                    for (int i = 0; i < 2; i++)
                        for (int c = 0; c < 2; c++) begin
                            if (frm[c] == prv[i][c])
                                cnt[i][c] = (cnt[i][c] < filt[i] - 1) ? cnt[i][c] + 1 : filt[i] - 1;
                            else
                                cnt[i][c] = 0;
                            prv[i][c] = frm[c];
                            if (cnt[i][c] == filt[i] - 1 && !cold_rst) begin
                                mchg[i][c] = !first[i][c] && (mpo[i][c] != frm[c]);
                                mpo[i][c] = frm[c];
                                mvalid[i] = 1'b1;
                                first[i][c] = 1'b0;
                            end
                        end
                    pos = en ? 0 : -1;
                end else if (pos == -1) begin
                    pos = en ? 0 : -1;
                end else begin
                    pos++;
                end
                if (pos == 0) begin
                    frm[0] = stim[0];
                    frm[1] = stim[1];
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        logic e_sclk, e_sld_n, e_fd, ps;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            e_sld_n = !(pos >= 0 && pos < 2 * DIV);
            e_fd    = (pos == FLEN - 1);
            if (pos >= 2 * DIV && pos < 2 * DIV * (NBIT + 1))
                e_sclk = (((pos - 2 * DIV) / DIV) % 2) == 1;
            else
                e_sclk = 1'b0;
            chk("ctrl_f1", 32'({sclk_a, sld_n_a, fd_a}), 32'({e_sclk, e_sld_n, e_fd}));
            chk("ctrl_f2", 32'({sclk_b, sld_n_b, fd_b}), 32'({e_sclk, e_sld_n, e_fd}));
            chk("po_f1", 32'(po_a), 32'({mpo[0][1], mpo[0][0]}));
            chk("po_f2", 32'(po_b), 32'({mpo[1][1], mpo[1][0]}));
            chk("stat_f1", 32'({pov_a, chg_a}), 32'({mvalid[0], mchg[0]}));
            chk("stat_f2", 32'({pov_b, chg_b}), 32'({mvalid[1], mchg[1]}));
            if (sclk_a === 1'b1 && ps === 1'b0) rises++;
            ps = sclk_a;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed scenario with literal expectations pinning the model.
    initial begin
        int t1, t2, n, k;
        warm_rst = 1'b1;
        cold_rst = 1'b1;
        en = 1'b0;
        stim = {8'h3C, 8'hA5};
        tick(3);
        chk("rst_ctrl", 32'({sclk_a, sld_n_a, fd_a, chg_a}), 32'h0000_0008);
        chk("rst_po", 32'({pov_a, po_a}), 32'h0000_0000);
        warm_rst = 1'b0;
        cold_rst = 1'b0;
        tick(2);
        en = 1'b1;

        wait_done("f1");
        t1 = cyc;
        tick(1);
        chk("f1_po_filt1", 32'(po_a), 32'h0000_3CA5);
        chk("f1_stat_filt1", 32'({pov_a, chg_a}), 32'h0000_0004);
        chk("f1_po_filt2", 32'({pov_b, po_b}), 32'h0000_0000);

        wait_done("f2");
        t2 = cyc;
        chk("frame_period", 32'(t2 - t1), 32'd37);
        stim = {8'h3C, 8'h01};
        tick(1);
        chk("f2_po_filt2", 32'({pov_b, po_b}), 32'h0001_3CA5);
        chk("f2_chg_filt2", 32'(chg_b), 32'h0000_0000);

        wait_done("f3");
        tick(1);
        chk("f3_po_filt1", 32'({chg_a, po_a}), 32'h0001_3C01);
        wait_done("f4");
        stim = {8'h3C, 8'h02};
        tick(1);
        chk("f4_po_filt2", 32'({chg_b, po_b}), 32'h0001_3C01);
        wait_done("f5");
        tick(1);
        chk("f5_hold_filt2", 32'({chg_b, po_b}), 32'h0000_3C01);
        wait_done("f6");
        stim = {8'hC3, 8'h5A};
        rises = 0;
        tick(1);
        chk("f6_commit_filt2", 32'({chg_b, po_b}), 32'h0001_3C02);

        wait_rises(4, "f7_bit3");
        en = 1'b0;
        wait_done("f7");
        chk("f7_rises", 32'(rises), 32'd8);
        stim = {8'h3C, 8'hA5};
        tick(1);
        chk("f7_commit_filt1", 32'({chg_a, po_a}), 32'h0003_C35A);
        tick(20);
        chk("idle_ctrl", 32'({sclk_a, sld_n_a, rises}), 32'({1'b0, 1'b1, 32'd8}));

        en = 1'b1;
        wait_done("f8");
        rises = 0;
        tick(1);
        chk("f8_po_filt1", 32'(po_a), 32'h0000_3CA5);
        wait_rises(2, "f9_shift");
        warm_rst = 1'b1;
        tick(2);
        chk("warm_po", 32'({pov_a, po_a}), 32'h0001_3CA5);
        chk("warm_ctrl", 32'({sclk_a, sld_n_a, fd_a}), 32'h0000_0002);
        warm_rst = 1'b0;
        k = 0;
        while (sld_n_a !== 1'b0 && k < 10) begin
            tick(1);
            k++;
        end
        n = 0;
        while (sld_n_a === 1'b0 && n < 50) begin
            n++;
            tick(1);
        end
        chk("warm_load_len", 32'(n), 32'd4);

        wait_done("f10");
        tick(10);
        cold_rst = 1'b1;
        tick(1);
        chk("cold_f1", 32'({pov_a, po_a}), 32'h0000_0000);
        chk("cold_f2", 32'({pov_b, po_b}), 32'h0000_0000);
        cold_rst = 1'b0;
        wait_done("f11");
        tick(1);
        chk("cold_commit_f1", 32'({pov_a, chg_a, po_a}), 32'h0004_3CA5);
        chk("cold_commit_f2", 32'({pov_b, chg_b, po_b}), 32'h0004_3CA5);

        en = 1'b0;
        wait_done("f12");
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
